// File: rtl/stack_cpu_p.sv
`default_nettype none
// ============================================================================
// Module   : stack_cpu_p
// Brief    : Parametrised 16-bit-instruction stack machine with handshaked
//            data port; STACK_CPU_P_MUL_EN enables the binary multiply func.
// Revision : 1.0
// ============================================================================
module stack_cpu_p #(
  parameter int DW    = 8,
  parameter int DEPTH = 16,
  parameter int PCW   = 10,
  parameter int AW    = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [15:0]    insn,
  output logic [PCW-1:0] pc,
  output logic [AW-1:0]  mem_addr,
  output logic           mem_rd,
  output logic           mem_wr,
  input  logic           mem_ready,
  input  logic [DW-1:0]  rd_data,
  output logic [DW-1:0]  wr_data,
  output logic           halted,
  output logic [1:0]     fault
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] c_depth = CW'(DEPTH);
  localparam logic [7:0] c_op_push = 8'h00, c_op_ld  = 8'h08, c_op_st  = 8'h0C,
                         c_op_sta  = 8'h0D, c_op_std = 8'h0E, c_op_jz  = 8'h10,
                         c_op_jmp  = 8'h11, c_op_bin = 8'h20, c_op_un  = 8'h21,
                         c_op_dup  = 8'h22, c_op_drop = 8'h23, c_op_halt = 8'hFF;

  typedef enum logic [1:0] {S_EXEC = 2'd0, S_MEM = 2'd1, S_WB = 2'd2, S_STOP = 2'd3} state_t;
  typedef enum logic [2:0] {A_NONE = 3'd0, A_PUSH = 3'd1, A_REPL = 3'd2,
                            A_POP = 3'd3, A_POP2P = 3'd4} act_t;

  state_t         r_state, w_next;
  logic [DW-1:0]  r_stk [DEPTH];
  logic [DW-1:0]  w_stk_nxt [DEPTH];
  logic [CW-1:0]  r_cnt;
  logic [PCW-1:0] r_pc, w_pc_nxt;
  logic [DW-1:0]  r_rd, r_wr_data, w_s0, w_s1, w_val, w_wdata;
  logic [AW-1:0]  r_mem_addr, w_addr;
  logic           r_mem_rd, r_mem_wr, r_halted;
  logic [1:0]     r_fault, w_fault, w_need;
  logic [7:0]     w_op, w_imm;
  logic           w_grow, w_illegal, w_halt, w_load, w_store, w_under, w_over, w_stop;
  act_t           w_act;

  // Decode is purely a function of insn and the stack, so WB re-derives the
  // same action EXEC checked (insn is held stable until pc moves).
  always_comb begin
    w_op = insn[15:8];
    w_imm = insn[7:0];
    w_s0 = r_stk[0];
    w_s1 = r_stk[1];
    w_need = 2'd0;
    w_grow = 1'b0;
    w_illegal = 1'b0;
    w_halt = 1'b0;
    w_load = 1'b0;
    w_store = 1'b0;
    w_act = A_NONE;
    w_val = '0;
    w_pc_nxt = r_pc + PCW'(1);
    w_addr = AW'(w_imm);
    w_wdata = w_s0;
    case (w_op)
      c_op_push: begin w_grow = 1'b1; w_act = A_PUSH; w_val = DW'(w_imm); end
      c_op_ld:   begin w_grow = 1'b1; w_load = 1'b1; w_act = A_PUSH; w_val = r_rd; end
      c_op_st:   begin w_need = 2'd1; w_store = 1'b1; w_act = A_POP; end
      c_op_sta, c_op_std: begin
        w_need = 2'd2;
        w_store = 1'b1;
        w_act = A_POP2P;
        w_addr = AW'(w_s0);
        w_wdata = w_s1;
        w_val = (w_op == c_op_sta) ? w_s0 : w_s1;
      end
      c_op_jz: begin
        w_need = 2'd1;
        w_act = A_POP;
        if (w_s0 == '0) w_pc_nxt = PCW'(w_imm);
      end
      c_op_jmp: w_pc_nxt = PCW'(w_imm);
      c_op_bin: begin
        w_need = 2'd2;
        w_act = A_POP2P;
        case (w_imm)
          8'h02: w_val = w_s0 + w_s1;
          8'h03: w_val = w_s0 - w_s1;
`ifdef STACK_CPU_P_MUL_EN
          8'h04: w_val = w_s0 * w_s1;
`endif
          8'h05: w_val = w_s0 & w_s1;
          8'h06: w_val = w_s0 | w_s1;
          8'h07: w_val = w_s0 ^ w_s1;
          8'h08: w_val = DW'(w_s0 < w_s1);
          8'h09: w_val = DW'(w_s0 == w_s1);
          default: w_illegal = 1'b1;
        endcase
      end
      c_op_un: begin
        w_need = 2'd1;
        w_act = A_REPL;
        case (w_imm)
          8'h00: w_val = ~w_s0;
          8'h01: w_val = -w_s0;
          8'h02: w_val = w_s0 << 1;
          8'h03: w_val = w_s0 >> 1;
          default: w_illegal = 1'b1;
        endcase
      end
      c_op_dup:  begin w_need = 2'd1; w_grow = 1'b1; w_act = A_PUSH; w_val = w_s0; end
      c_op_drop: begin w_need = 2'd1; w_act = A_POP; end
      c_op_halt: w_halt = 1'b1;
      default:   w_illegal = 1'b1;
    endcase
    w_under = (r_cnt < CW'(w_need));
    w_over = w_grow && (r_cnt == c_depth);
    w_fault = w_illegal ? 2'b11 : w_under ? 2'b10 : w_over ? 2'b01 : 2'b00;
    w_stop = w_halt | w_illegal | w_under | w_over;
  end

  always_comb begin
    w_stk_nxt = r_stk;
    case (w_act)
      A_PUSH: begin
        for (int i = 1; i < DEPTH; i++) w_stk_nxt[i] = r_stk[i-1];
        w_stk_nxt[0] = w_val;
      end
      A_REPL: w_stk_nxt[0] = w_val;
      A_POP, A_POP2P: begin
        for (int i = 0; i < DEPTH - 1; i++) w_stk_nxt[i] = r_stk[i+1];
        w_stk_nxt[DEPTH-1] = '0;
        if (w_act == A_POP2P) w_stk_nxt[0] = w_val;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_EXEC:  w_next = w_stop ? S_STOP : (w_load | w_store) ? S_MEM : S_WB;
      S_MEM:   if (mem_ready) w_next = S_WB;
      S_WB:    w_next = S_EXEC;
      default: w_next = S_STOP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_EXEC;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= '0;
      r_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) r_stk[i] <= '0;
      r_mem_rd <= 1'b0;
      r_mem_wr <= 1'b0;
      r_mem_addr <= '0;
      r_wr_data <= '0;
      r_rd <= '0;
      r_halted <= 1'b0;
      r_fault <= 2'b00;
    end else begin
      case (r_state)
        S_EXEC: begin
          if (w_stop) begin
            r_halted <= 1'b1;
            r_fault <= w_fault;
          end else if (w_load | w_store) begin
            r_mem_rd <= w_load;
            r_mem_wr <= w_store;
            r_mem_addr <= w_addr;
            r_wr_data <= w_wdata;
          end
        end
        S_MEM: begin
          if (mem_ready) begin
            r_mem_rd <= 1'b0;
            r_mem_wr <= 1'b0;
            if (r_mem_rd) r_rd <= rd_data;
          end
        end
        S_WB: begin
          r_pc <= w_pc_nxt;
          r_stk <= w_stk_nxt;
          if (w_act == A_PUSH) r_cnt <= r_cnt + CW'(1);
          else if (w_act == A_POP || w_act == A_POP2P) r_cnt <= r_cnt - CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign pc = r_pc;
  assign mem_addr = r_mem_addr;
  assign mem_rd = r_mem_rd;
  assign mem_wr = r_mem_wr;
  assign wr_data = r_wr_data;
  assign halted = r_halted;
  assign fault = r_fault;
endmodule
`default_nettype wire
